uart_echo_ctrl: RTL

- Parametrised UART echo/loopback controller; sits between the uart block's FIFO-side interface and the board I/O.
- Pops received words from the UART, adds a fixed offset, and buffers them in an internal FIFO.
- Writes buffered words back to the UART transmitter, either automatically or one word per debounced button press.
- Exposes occupancy and last-received status for LEDs and seven-segment display.

---
 rtl/uart_echo_pkg.sv | 16 +
 rtl/uart_echo_ctrl_btn_debounce.sv | 82 ++++++++
 rtl/uart_echo_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and default constants for the UART echo controller.
package uart_echo_pkg;

  localparam int DEFAULT_DBIT  = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Debouncer states: settled low, waiting to confirm high, settled high,
  // waiting to confirm low.
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

endpackage

// File: rtl/uart_echo_ctrl_btn_debounce.sv
// Push-button debouncer: 2-flop synchroniser followed by a four-state
// FSM. Emits a one-cycle tick when a press has been stable for DB_TICKS
// clock cycles.
module btn_debounce
  import uart_echo_pkg::*;
#(
  parameter int DB_TICKS = 2**20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_tick
);

  localparam int              CW   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [CW-1:0]   LOAD = CW'(DB_TICKS - 1);

  logic            r_sync0;
  logic            r_sync1;
  db_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_tick;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce FSM; tick is registered and fires only on a confirmed press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        ZERO: begin
          if (r_sync1) begin
            r_state <= WAIT1;
            r_cnt   <= LOAD;
          end
        end
        WAIT1: begin
          if (!r_sync1) begin
            r_state <= ZERO;
          end else if (r_cnt == '0) begin
            r_state <= ONE;
            r_tick  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ONE: begin
          if (!r_sync1) begin
            r_state <= WAIT0;
            r_cnt   <= LOAD;
          end
        end
        WAIT0: begin
          if (r_sync1) begin
            r_state <= ONE;
          end else if (r_cnt == '0) begin
            r_state <= ZERO;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ZERO;
      endcase
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART echo controller: pops RX words, adds OFFSET, buffers them in a
// circular RAM and writes them back to the TX FIFO, either freely (auto)
// or one word per debounced button press (manual).
// Optional build macro UART_ECHO_STATS_EN adds 16-bit rx/tx word counters.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DBIT     = DEFAULT_DBIT,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int OFFSET   = 1,
  parameter int DB_TICKS = 2**20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_rx_empty,
  input  logic [DBIT-1:0]          i_r_data,
  output logic                     o_rd_uart,
  input  logic                     i_tx_full,
  output logic [DBIT-1:0]          o_w_data,
  output logic                     o_wr_uart,
  input  logic                     i_btn,
  input  logic                     i_manual,
  output logic [DBIT-1:0]          o_last_rx,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_buf_full,
  output logic                     o_buf_empty
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]              o_rx_count,
  output logic [15:0]              o_tx_count
`endif
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
  localparam logic [DBIT-1:0] OFS      = DBIT'(OFFSET);

  logic [DBIT-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_buf_full;
  logic            r_buf_empty;
  logic            r_rd_uart;
  logic            r_wr_uart;
  logic [DBIT-1:0] r_w_data;
  logic [DBIT-1:0] r_last_rx;
  logic            r_pending;

  logic            w_tick;
  logic            w_push;
  logic            w_send_en;
  logic            w_send;
  logic [LW-1:0]   w_level_next;

  btn_debounce #(
    .DB_TICKS (DB_TICKS)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (i_btn),
    .o_tick (w_tick)
  );

  // Push happens in the rd_uart cycle; a send is decided one cycle before
  // wr_uart is shown, so the buffer head is popped at the decision edge.
  always_comb begin
    w_push       = r_rd_uart;
    w_send_en    = !i_manual || r_pending;
    w_send       = w_send_en && !r_buf_empty && !i_tx_full && !r_wr_uart;
    w_level_next = r_level;
    if (w_push && !w_send) begin
      w_level_next = r_level + LW'(1);
    end else if (!w_push && w_send) begin
      w_level_next = r_level - LW'(1);
    end
  end

  // Buffer RAM write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_r_data + OFS;
    end
  end

  // Strobes, pointers, occupancy and the registered read of the head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_uart   <= 1'b0;
      r_wr_uart   <= 1'b0;
      r_w_data    <= '0;
      r_last_rx   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_buf_full  <= 1'b0;
      r_buf_empty <= 1'b1;
    end else begin
      // rx_empty lags a pop by one cycle, so never pop on back-to-back cycles
      r_rd_uart <= !i_rx_empty && !r_buf_full && !r_rd_uart;
      r_wr_uart <= w_send;
      if (w_send) begin
        r_w_data <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_last_rx <= i_r_data;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      r_level     <= w_level_next;
      r_buf_full  <= (w_level_next == FULL_LVL);
      r_buf_empty <= (w_level_next == '0);
    end
  end

  // Manual-mode send permission: one pending press at most, consumed by a
  // send, and dropped whenever auto mode is selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (!i_manual) begin
      r_pending <= 1'b0;
    end else if (w_send) begin
      r_pending <= 1'b0;
    end else if (w_tick) begin
      r_pending <= 1'b1;
    end
  end

  assign o_rd_uart   = r_rd_uart;
  assign o_wr_uart   = r_wr_uart;
  assign o_w_data    = r_w_data;
  assign o_last_rx   = r_last_rx;
  assign o_level     = r_level;
  assign o_buf_full  = r_buf_full;
  assign o_buf_empty = r_buf_empty;

`ifdef UART_ECHO_STATS_EN
  logic [15:0] r_rx_count;
  logic [15:0] r_tx_count;

  // Word counters for each RX pop and TX push; wrap at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_count <= '0;
      r_tx_count <= '0;
    end else begin
      if (r_rd_uart) r_rx_count <= r_rx_count + 16'd1;
      if (r_wr_uart) r_tx_count <= r_tx_count + 16'd1;
    end
  end

  assign o_rx_count = r_rx_count;
  assign o_tx_count = r_tx_count;
`endif

endmodule
